fl_vadd_seq: RTL and testbench



---
 rtl/fl_vadd_pkg.sv | 6 +
 rtl/fl_vadd_elem_cnt.sv | 21 ++
 rtl/fl_vadd_seq.sv | 102 ++++++++++
 tb/tb_fl_vadd_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fl_vadd_pkg.sv
// fl_vadd_pkg: shared state encoding and default widths for the fl_vadd job sequencer
package fl_vadd_pkg;
    localparam int LEN_W_DEF  = 16;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/fl_vadd_elem_cnt.sv
// fl_vadd_elem_cnt: element counter with clear, increment and limit compare; holds at the limit
module fl_vadd_elem_cnt
    import fl_vadd_pkg::*;
#(
    parameter int W = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         below
);
    assign below = cnt < limit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && below) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/fl_vadd_seq.sv
// fl_vadd_seq: job sequencer gating x/y streams into fl_vadd and framing its results
module fl_vadd_seq
    import fl_vadd_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  out_count,
    input  logic [DATA_W-1:0] s_x_data,
    input  logic              s_x_valid,
    output logic              s_x_ready,
    input  logic [DATA_W-1:0] s_y_data,
    input  logic              s_y_valid,
    output logic              s_y_ready,
    output logic [DATA_W-1:0] add_x_data,
    output logic              add_x_valid,
    input  logic              add_x_ready,
    output logic [DATA_W-1:0] add_y_data,
    output logic              add_y_valid,
    input  logic              add_y_ready,
    input  logic [DATA_W-1:0] add_out_data,
    input  logic              add_out_valid,
    output logic              add_out_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);
    state_t           state, state_nx;
    logic [LEN_W-1:0] len_q, x_cnt, y_cnt, o_cnt;
    logic             x_below, y_below, o_below;
    logic             accept, run, coll, x_en, y_en, c_en;
    logic             x_hs, y_hs, o_hs, o_last, fin;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) len_q <= cfg_len;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (cfg_len != '0) ? RUN : DONE;
            RUN:     state_nx = fin ? DONE : ((x_cnt == len_q && y_cnt == len_q) ? DRAIN : RUN);
            DRAIN:   state_nx = fin ? DONE : DRAIN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
        run  = state == RUN;
        coll = (state == RUN) || (state == DRAIN);
    end

    assign x_en        = run && x_below;
    assign add_x_valid = s_x_valid && x_en;
    assign s_x_ready   = add_x_ready && x_en;
    assign add_x_data  = s_x_data;
    assign x_hs        = add_x_valid && add_x_ready;

    assign y_en        = run && y_below;
    assign add_y_valid = s_y_valid && y_en;
    assign s_y_ready   = add_y_ready && y_en;
    assign add_y_data  = s_y_data;
    assign y_hs        = add_y_valid && add_y_ready;

    assign c_en          = coll && o_below;
    assign m_valid       = add_out_valid && c_en;
    assign add_out_ready = m_ready && c_en;
    assign m_data        = add_out_data;
    assign o_last        = o_cnt == len_q - LEN_W'(1);
    assign m_last        = m_valid && o_last;
    assign o_hs          = m_valid && m_ready;
    assign fin           = o_hs && o_last;
    assign out_count     = o_cnt;

    fl_vadd_elem_cnt #(.W(LEN_W)) u_x_cnt (
        .clk(clk), .rst_n(rst_n), .clr(accept), .inc(x_hs), .limit(len_q), .cnt(x_cnt), .below(x_below)
    );
    fl_vadd_elem_cnt #(.W(LEN_W)) u_y_cnt (
        .clk(clk), .rst_n(rst_n), .clr(accept), .inc(y_hs), .limit(len_q), .cnt(y_cnt), .below(y_below)
    );
    fl_vadd_elem_cnt #(.W(LEN_W)) u_o_cnt (
        .clk(clk), .rst_n(rst_n), .clr(accept), .inc(o_hs), .limit(len_q), .cnt(o_cnt), .below(o_below)
    );
endmodule

// File: tb/tb_fl_vadd_seq.sv
// tb_fl_vadd_seq: randomized job-level checks of fl_vadd_seq against a queue-based adder and reference
module tb_fl_vadd_seq;
    localparam int LW = 4;
    localparam int DW = 32;
    localparam int BOUND = 400;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [LW-1:0] cfg_len;
    logic          start;
    logic          busy, done;
    logic [LW-1:0] out_count;
    logic [DW-1:0] s_x_data, s_y_data, add_x_data, add_y_data, add_out_data, m_data;
    logic          s_x_valid, s_x_ready, s_y_valid, s_y_ready;
    logic          add_x_valid, add_x_ready, add_y_valid, add_y_ready;
    logic          add_out_valid, add_out_ready, m_valid, m_ready, m_last;

    logic [DW-1:0] xsrc[$], ysrc[$], qx[$], qy[$], exp_d[$], got_d[$];
    bit            got_l[$];
    int            x_hs_n, y_hs_n, job_cyc, y_delay;
    bit            rnd;
    int            n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    fl_vadd_seq #(.LEN_W(LW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .start(start), .busy(busy), .done(done),
        .out_count(out_count),
        .s_x_data(s_x_data), .s_x_valid(s_x_valid), .s_x_ready(s_x_ready),
        .s_y_data(s_y_data), .s_y_valid(s_y_valid), .s_y_ready(s_y_ready),
        .add_x_data(add_x_data), .add_x_valid(add_x_valid), .add_x_ready(add_x_ready),
        .add_y_data(add_y_data), .add_y_valid(add_y_valid), .add_y_ready(add_y_ready),
        .add_out_data(add_out_data), .add_out_valid(add_out_valid), .add_out_ready(add_out_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    // Environment: upstream sources, a queue-based adder and the result sink
    initial begin
        bit            hx, hy, ho, ml;
        logic [DW-1:0] dx, dy, dm;
        s_x_valid = 0; s_y_valid = 0; s_x_data = '0; s_y_data = '0;
        add_x_ready = 1; add_y_ready = 1; add_out_valid = 0; add_out_data = '0; m_ready = 1;
        forever begin
            @(negedge clk);
            #4;
            hx = add_x_valid && add_x_ready; dx = add_x_data;
            hy = add_y_valid && add_y_ready; dy = add_y_data;
            ho = m_valid && m_ready; dm = m_data; ml = m_last;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                qx.delete(); qy.delete();
            end else begin
                if (hx && xsrc.size() > 0) begin void'(xsrc.pop_front()); qx.push_back(dx); x_hs_n++; end
                if (hy && ysrc.size() > 0) begin void'(ysrc.pop_front()); qy.push_back(dy); y_hs_n++; end
                if (ho) begin
                    void'(qx.pop_front()); void'(qy.pop_front());
                    got_d.push_back(dm); got_l.push_back(ml);
                end
            end
            job_cyc++;
            s_x_valid = xsrc.size() > 0;
            s_x_data = (xsrc.size() > 0) ? xsrc[0] : '0;
            s_y_valid = ysrc.size() > 0 && job_cyc >= y_delay;
            s_y_data = (ysrc.size() > 0) ? ysrc[0] : '0;
            add_out_valid = qx.size() > 0 && qy.size() > 0;
            add_out_data = add_out_valid ? qx[0] + qy[0] : '0;
            add_x_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            add_y_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic load(input int len);
        logic [DW-1:0] a, b;
        xsrc.delete(); ysrc.delete(); exp_d.delete(); got_d.delete(); got_l.delete();
        x_hs_n = 0; y_hs_n = 0;
        for (int i = 0; i <= len; i++) begin
            a = $urandom; b = $urandom;
            xsrc.push_back(a); ysrc.push_back(b);
            if (i < len) exp_d.push_back(a + b);
        end
    endtask

    task automatic start_job(input int len, input int ydel);
        @(negedge clk);
        cfg_len = LW'(len);
        start = 1;
        job_cyc = 0;
        y_delay = ydel;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_job(input string name, input int len, input int ydel, input bit r, input bit poke);
        int done_n = 0, done_at = -1;
        logic busy0, busy_after = 1'bx;
        rnd = r;
        load(len);
        start_job(len, ydel);
        for (int c = 0; c < BOUND; c++) begin
            if (c > 0) @(negedge clk);
            #2;
            if (c == 0) busy0 = busy;
            if (poke && c == 1) begin start = 1; cfg_len = 4'd7; end
            if (poke && c == 2) start = 0;
            if (done === 1'b1) begin done_n++; done_at = c; end
            else if (done_at >= 0) begin busy_after = busy; break; end
        end
        n_vec++;
        if (done_at < 0) begin n_err++; $display("FAIL %s timeout: no done within %0d cycles", name, BOUND); end
        n_vec++;
        if (busy_after !== 1'b0) begin n_err++; $display("FAIL %s busy_after_done: got %b want 0", name, busy_after); end
        n_vec++;
        if (done_n != 1) begin n_err++; $display("FAIL %s done_pulses: got %0d want 1", name, done_n); end
        n_vec++;
        if (len == 0 && done_at != 0) begin n_err++; $display("FAIL %s zero_len_latency: got %0d want 0", name, done_at); end
        else if (len != 0 && busy0 !== 1'b1) begin n_err++; $display("FAIL %s busy_in_job: got %b want 1", name, busy0); end
        n_vec++;
        if (x_hs_n != len || y_hs_n != len) begin
            n_err++; $display("FAIL %s handshakes: got x=%0d y=%0d want %0d", name, x_hs_n, y_hs_n, len);
        end
        n_vec++;
        if (xsrc.size() != 1 || ysrc.size() != 1) begin
            n_err++; $display("FAIL %s leftover_beats: got x=%0d y=%0d want 1", name, xsrc.size(), ysrc.size());
        end
        n_vec++;
        if (s_x_ready !== 1'b0 || s_y_ready !== 1'b0) begin
            n_err++; $display("FAIL %s idle_ready: got x=%b y=%b want 0", name, s_x_ready, s_y_ready);
        end
        n_vec++;
        if (out_count !== LW'(len)) begin n_err++; $display("FAIL %s out_count: got %0d want %0d", name, out_count, len); end
        n_vec++;
        if (got_d.size() != len) begin n_err++; $display("FAIL %s result_count: got %0d want %0d", name, got_d.size(), len); end
        for (int i = 0; i < len && i < got_d.size(); i++) begin
            n_vec++;
            if (got_d[i] !== exp_d[i] || got_l[i] != (i == len - 1)) begin
                n_err++;
                $display("FAIL %s result[%0d]: got %h last=%0d want %h last=%0d", name, i, got_d[i], got_l[i], exp_d[i], i == len - 1);
            end
        end
        repeat (3) @(negedge clk);
        #2;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s stays_idle: got busy=%b want 0", name, busy); end
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({busy, done, out_count, s_x_ready, s_y_ready, add_x_valid, add_y_valid, m_valid, m_last, add_out_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b cnt=%0d sxr=%b syr=%b axv=%b ayv=%b mv=%b ml=%b aor=%b want all 0",
                     busy, done, out_count, s_x_ready, s_y_ready, add_x_valid, add_y_valid, m_valid, m_last, add_out_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();        run_job("basic4", 4, 0, 0, 0);  endtask
    task automatic test_zero_len();     run_job("zero", 0, 0, 0, 0);    endtask
    task automatic test_lag_backpress(); run_job("lag8", 8, 5, 1, 0);   endtask

    task automatic test_back_to_back();
        run_job("b2b_a", 3, 0, 0, 1);
        run_job("b2b_b", 2, 0, 0, 0);
    endtask

    task automatic test_mid_reset();
        int c;
        rnd = 1;
        load(6);
        start_job(6, 0);
        for (c = 0; c < BOUND && x_hs_n < 2; c++) @(negedge clk);
        n_vec++;
        if (x_hs_n < 2) begin n_err++; $display("FAIL mid_reset_progress: got %0d x beats want >=2", x_hs_n); end
        #2;
        rst_n = 0;
        #1;
        n_vec++;
        if ({busy, done, out_count, s_x_ready, s_y_ready, add_x_valid, add_y_valid, m_valid, m_last, add_out_ready} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_async: got busy=%b cnt=%0d sxr=%b syr=%b axv=%b ayv=%b mv=%b aor=%b want all 0",
                     busy, out_count, s_x_ready, s_y_ready, add_x_valid, add_y_valid, m_valid, add_out_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        run_job("after_rst", 1, 0, 0, 0);
    endtask

    task automatic test_max_len();      run_job("max15", 15, 0, 1, 0);  endtask

    initial begin
        start = 0;
        cfg_len = '0;
        rnd = 0;
        y_delay = 0;
        job_cyc = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_lag_backpress();
        test_back_to_back();
        test_mid_reset();
        test_max_len();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
